// File: rtl/programmable_clock_generator.sv
// Multi-channel programmable clock divider. Each channel has a registered
// counter, double-buffered divisor and glitch-free flop-driven outputs.
module programmable_clock_generator #(
   parameter int NUM_CH = 4,
   parameter int DIV_W  = 8,
   parameter logic [NUM_CH*DIV_W-1:0] DIV_INIT = {NUM_CH{DIV_W'(2)}},
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clock_in,
   input  logic              reset,
   input  logic [NUM_CH-1:0] en,
   input  logic              sync,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [DIV_W-1:0]  wr_div,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tog_out,
   output logic [NUM_CH-1:0] strobe,
   output logic [NUM_CH-1:0] pend
);

   // Divisors 0 and 1 cannot produce a valid waveform, so they run as 2.
   function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
      return (d < DIV_W'(2)) ? DIV_W'(2) : d;
   endfunction

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [DIV_W-1:0] d_q, d_d, s_q, s_d, cnt_q, cnt_d, e_cur;
      logic             run_q, run_d, pend_q, pend_d;
      logic             clk_q, clk_d, tog_q, tog_d, stb_q, stb_d;
      logic             hit, tc;

      always_comb begin
         e_cur  = eff_div(d_q);
         hit    = wr_en && (wr_ch == CH_W'(i));
         tc     = run_q && (cnt_q == e_cur - DIV_W'(1));
         d_d    = d_q;
         s_d    = s_q;
         cnt_d  = cnt_q;
         run_d  = run_q;
         pend_d = pend_q;
         clk_d  = clk_q;
         tog_d  = tog_q;
         stb_d  = stb_q;
         if (!en[i]) begin
            run_d = 1'b0;
            cnt_d = '0;
            clk_d = 1'b0;
            tog_d = 1'b0;
            stb_d = 1'b0;
            if (hit) d_d = wr_div;
         end else if (!run_q) begin
            // first enabled cycle always opens a fresh period
            run_d = 1'b1;
            cnt_d = '0;
            clk_d = 1'b0;
            stb_d = 1'b1;
            tog_d = ~tog_q;
            if (hit) begin
               s_d    = wr_div;
               pend_d = 1'b1;
            end
         end else if (sync || tc) begin
            cnt_d  = '0;
            clk_d  = 1'b0;
            stb_d  = 1'b1;
            tog_d  = ~tog_q;
            pend_d = 1'b0;
            if (hit)         d_d = wr_div;
            else if (pend_q) d_d = s_q;
         end else begin
            cnt_d = cnt_q + DIV_W'(1);
            clk_d = (cnt_d >= (e_cur >> 1));
            stb_d = 1'b0;
            if (hit) begin
               s_d    = wr_div;
               pend_d = 1'b1;
            end
         end
      end

      always_ff @(posedge clock_in or posedge reset) begin
         if (reset) begin
            d_q    <= DIV_INIT[i*DIV_W +: DIV_W];
            s_q    <= DIV_INIT[i*DIV_W +: DIV_W];
            cnt_q  <= '0;
            run_q  <= 1'b0;
            pend_q <= 1'b0;
            clk_q  <= 1'b0;
            tog_q  <= 1'b0;
            stb_q  <= 1'b0;
         end else begin
            d_q    <= d_d;
            s_q    <= s_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            pend_q <= pend_d;
            clk_q  <= clk_d;
            tog_q  <= tog_d;
            stb_q  <= stb_d;
         end
      end

      assign clk_out[i] = clk_q;
      assign tog_out[i] = tog_q;
      assign strobe[i]  = stb_q;
      assign pend[i]    = pend_q;
   end

endmodule
